imm_encoder: RTL and testbench

Instruction-word encoder for the CC pipeline: it accepts high-level immediate commands (load 32-bit constant, wait N cycles, raw pass-through) and emits a stream of 32-bit instruction words that `imm_gen` decodes back to the original values. Oversized immediates are split into legal multi-word sequences: LDI+LDUI for constants, repeated QWAIT for long waits. It sits between the host/command front-end and the instruction memory write port.

---
 rtl/cc_enc_pkg.sv | 33 +++
 rtl/imm_pack.sv | 28 ++
 rtl/imm_encoder.sv | 215 +++++++++++++++++++++
 tb/tb_imm_encoder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_enc_pkg.sv
// cc_enc_pkg: shared constants and types for the CC instruction-word encoder.
//   - opcode constants for the LDI / LDUI / QWAIT word formats
//   - command opcode enum, encoder FSM state enum, word-kind selector
//   - QW_MAX: largest cycle count that fits one QWAIT payload
package cc_enc_pkg;

    localparam logic [6:0]  OPC_LDI   = 7'h37;
    localparam logic [6:0]  OPC_LDUI  = 7'h17;
    localparam logic [6:0]  OPC_QWAIT = 7'h7B;
    localparam logic [19:0] QW_MAX    = 20'hFFFFF;

    typedef enum logic [1:0] {
        OP_LOADI   = 2'd0,
        OP_QWAIT   = 2'd1,
        OP_PASS    = 2'd2,
        OP_ILLEGAL = 2'd3
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LDI  = 3'd1,
        ST_LDUI = 3'd2,
        ST_QW   = 3'd3,
        ST_PASS = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        WK_LDI   = 2'd0,
        WK_LDUI  = 2'd1,
        WK_QWAIT = 2'd2
    } word_kind_t;

endpackage

// File: rtl/imm_pack.sv
// imm_pack: combinational instruction-word formatter.
//   kind  : which word format to build (LDI, LDUI, QWAIT)
//   rd    : destination register (LDI / LDUI only)
//   value : LDI uses value[19:0], LDUI uses value[31:17],
//           QWAIT uses value[19:0] as the cycle count payload
//   word  : formatted 32-bit instruction word
module imm_pack
    import cc_enc_pkg::*;
(
    input  word_kind_t  kind,
    input  logic [4:0]  rd,
    input  logic [31:0] value,
    output logic [31:0] word
);

    always_comb begin
        word = '0;
        case (kind)
            WK_LDI:   word = {value[19:0], rd, OPC_LDI};
            // LDUI carries rd in both the rs and rd fields so the decoder
            // merges the upper 15 bits into the register LDI just wrote.
            WK_LDUI:  word = {value[31:17], rd, rd, OPC_LDUI};
            WK_QWAIT: word = {value[19:0], 5'b0, OPC_QWAIT};
            default:  word = '0;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: turns immediate commands into a stream of 32-bit
// instruction words (LDI / LDI+LDUI for constants, repeated QWAIT for
// long waits, raw pass-through).
//   clk, rst           : clock, asynchronous active-high reset
//   cmd_valid/ready    : command handshake (ready only while idle)
//   cmd_op/rd/data     : command opcode, destination register, operand
//   out_valid/ready    : output word handshake
//   out_instr/out_last : registered word and end-of-command marker
//   cmd_err            : one-cycle pulse when an illegal op is accepted
//   busy               : high while a command is being emitted
module imm_encoder
    import cc_enc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_rd,
    input  logic [31:0] cmd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        cmd_err,
    output logic        busy
);

    // Saturate a remaining wait count to what one QWAIT word can carry.
    function automatic logic [19:0] sat_payload(input logic [31:0] rem);
        if (rem > {12'd0, QW_MAX}) begin
            return QW_MAX;
        end
        return rem[19:0];
    endfunction

    // A constant needs only LDI when it equals the sign extension of its
    // low 20 bits.
    function automatic logic fits_ldi(input logic [31:0] v);
        return v == {{12{v[19]}}, v[19:0]};
    endfunction

    state_t      state_q, state_d;
    cmd_op_t     op;
    logic        hs;
    logic        valid_d, last_d, err_d, load_cmd;
    logic [31:0] instr_d;
    logic [31:0] rem_q, rem_d, rem_after;
    logic [31:0] val_q;
    logic [4:0]  rd_q;
    logic [19:0] cmd_payload, next_payload;

    word_kind_t  pk_kind;
    logic [4:0]  pk_rd;
    logic [31:0] pk_val;
    logic [31:0] pk_word;

    assign op        = cmd_op_t'(cmd_op);
    assign hs        = out_valid & out_ready;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

    // Payload of the word being offered now is sat(rem); rem_after is what
    // is left once that word is taken.
    assign cmd_payload  = sat_payload(cmd_data);
    assign rem_after    = rem_q - {12'd0, sat_payload(rem_q)};
    assign next_payload = sat_payload(rem_after);

    // Select what the formatter builds: the first word of a new command
    // while idle, otherwise the follow-on word of the current command.
    always_comb begin
        pk_kind = WK_LDI;
        pk_rd   = cmd_rd;
        pk_val  = cmd_data;
        case (state_q)
            ST_IDLE: begin
                if (op == OP_QWAIT) begin
                    pk_kind = WK_QWAIT;
                    pk_val  = {12'd0, cmd_payload};
                end
            end
            ST_LDI: begin
                pk_kind = WK_LDUI;
                pk_rd   = rd_q;
                pk_val  = val_q;
            end
            ST_QW: begin
                pk_kind = WK_QWAIT;
                pk_val  = {12'd0, next_payload};
            end
            default: ;
        endcase
    end

    imm_pack u_pack (
        .kind  (pk_kind),
        .rd    (pk_rd),
        .value (pk_val),
        .word  (pk_word)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        valid_d  = out_valid;
        instr_d  = out_instr;
        last_d   = out_last;
        err_d    = 1'b0;
        rem_d    = rem_q;
        load_cmd = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    load_cmd = 1'b1;
                    case (op)
                        OP_LOADI: begin
                            state_d = ST_LDI;
                            valid_d = 1'b1;
                            instr_d = pk_word;
                            last_d  = fits_ldi(cmd_data);
                        end
                        OP_QWAIT: begin
                            // A zero count visits QW for one cycle with no
                            // word offered, then falls back to idle.
                            state_d = ST_QW;
                            rem_d   = cmd_data;
                            if (cmd_data != 32'd0) begin
                                valid_d = 1'b1;
                                instr_d = pk_word;
                                last_d  = ({12'd0, cmd_payload} == cmd_data);
                            end
                        end
                        OP_PASS: begin
                            state_d = ST_PASS;
                            valid_d = 1'b1;
                            instr_d = cmd_data;
                            last_d  = 1'b1;
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_LDI: begin
                if (hs) begin
                    if (out_last) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = ST_LDUI;
                        instr_d = pk_word;
                        last_d  = 1'b1;
                    end
                end
            end
            ST_QW: begin
                if (!out_valid) begin
                    state_d = ST_IDLE;
                end else if (hs) begin
                    rem_d = rem_after;
                    if (out_last) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        instr_d = pk_word;
                        last_d  = ({12'd0, next_payload} == rem_after);
                    end
                end
            end
            ST_LDUI, ST_PASS: begin
                if (hs) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_last  <= 1'b0;
            cmd_err   <= 1'b0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            out_valid <= valid_d;
            out_instr <= instr_d;
            out_last  <= last_d;
            cmd_err   <= err_d;
            rem_q     <= rem_d;
        end
    end

    // Operand capture for the LDUI follow-on word; pure data, no reset.
    always_ff @(posedge clk) begin
        if (load_cmd) begin
            val_q <= cmd_data;
            rd_q  <= cmd_rd;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: table-driven, hand-written and randomized checks of
// imm_encoder against a count-down reference model and an imm_gen-style
// word decoder.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [4:0]  cmd_rd = 5'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_last;
    logic        cmd_err;
    logic        busy;

    imm_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_data  (cmd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_last  (out_last),
        .cmd_err   (cmd_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int err_seen = 0;
    int valid_seen = 0;
    bit rand_ready = 1'b0;

    logic [32:0] got_q[$];   // {last, word} per handshake
    int          got_t[$];   // cycle of each handshake
    logic [32:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  rd;
        logic [31:0] data;
        int          nw;
        logic [32:0] w0;
        logic [32:0] w1;
        logic [32:0] w2;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Sample just after the falling edge, then advance one full cycle.
    task automatic step();
        logic        stall;
        logic [32:0] held;
        if (rand_ready) out_ready = ($urandom_range(0, 99) < 70);
        stall = out_valid && !out_ready;
        held  = {out_last, out_instr};
        if (out_valid && out_ready) begin
            got_q.push_back(held);
            got_t.push_back(cyc);
        end
        if (cmd_err) err_seen++;
        if (out_valid) valid_seen++;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (stall && !rst)
            check("hold", {30'd0, out_valid, out_last, out_instr}, {30'd0, 1'b1, held});
    endtask

    task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] d);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_rd = rd;
        cmd_data = d;
        while (!acc && guard < 100) begin
            acc = cmd_ready;
            if (acc) acc_cyc = cyc;
            step();
            guard++;
        end
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom);
        cmd_rd = 5'($urandom);
        cmd_data = $urandom;
        if (!acc) timeout_fail("accept");
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((busy || out_valid) && guard < 6000) begin
            step();
            guard++;
        end
        if (busy || out_valid) timeout_fail("drain");
        check("ready_after", 64'(cmd_ready), 64'd1);
        step();
        step();
    endtask

    // Reference: split commands into words from plain arithmetic.
    task automatic model(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] d,
                         output int exp_err);
        logic [31:0] r32;
        int signed   sd;
        longint      n;
        longint      p;
        exp_q.delete();
        exp_err = 0;
        r32 = {27'd0, rd};
        sd = d;
        case (op)
            2'd0: begin
                if (sd >= -524288 && sd <= 524287) begin
                    exp_q.push_back({1'b1, ((d & 32'h000FFFFF) << 12) | (r32 << 7) | 32'h37});
                end else begin
                    exp_q.push_back({1'b0, ((d & 32'h000FFFFF) << 12) | (r32 << 7) | 32'h37});
                    exp_q.push_back({1'b1, (d & 32'hFFFE0000) | (r32 << 12) | (r32 << 7) | 32'h17});
                end
            end
            2'd1: begin
                n = longint'(d);
                while (n > 0) begin
                    p = (n > 1048575) ? 1048575 : n;
                    n = n - p;
                    exp_q.push_back({(n == 0), (32'(p) << 12) | 32'h7B});
                end
            end
            2'd2: exp_q.push_back({1'b1, d});
            default: exp_err = 1;
        endcase
    endtask

    // imm_gen-style reconstruction of the emitted words.
    function automatic logic [31:0] decode_got();
        logic [31:0] r;
        logic [31:0] w;
        r = '0;
        for (int i = 0; i < got_q.size(); i++) begin
            w = got_q[i][31:0];
            if (w[6:0] == 7'h37)      r = {{12{w[31]}}, w[31:12]};
            else if (w[6:0] == 7'h17) r = {w[31:17], r[16:0]};
            else if (w[6:0] == 7'h7B) r = r + {12'd0, w[31:12]};
        end
        return r;
    endfunction

    task automatic run(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] d,
                       input string tag, input bit full_rate);
        int exp_err;
        got_q.delete();
        got_t.delete();
        err_seen = 0;
        model(op, rd, d, exp_err);
        send(op, rd, d);
        drain();
        check($sformatf("%s_nwords", tag), 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        check($sformatf("%s_err", tag), 64'(err_seen), 64'(exp_err));
        if ((op == 2'd0 || op == 2'd1) && got_q.size() > 0)
            check($sformatf("%s_decode", tag), 64'(decode_got()), 64'(d));
        if (full_rate && got_t.size() > 0) begin
            check($sformatf("%s_latency", tag), 64'(got_t[0]), 64'(acc_cyc + 1));
            for (int i = 1; i < got_t.size(); i++)
                check($sformatf("%s_gap%0d", tag, i), 64'(got_t[i] - got_t[i-1]), 64'd1);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int vs;
        logic [1:0]  rop;
        logic [31:0] rd32;
        logic [31:0] rdat;

        tbl[0]  = '{2'd0, 5'd5,  32'h0007FFFF, 1, {1'b1, 32'h7FFFF2B7}, 33'd0, 33'd0};
        tbl[1]  = '{2'd0, 5'd1,  32'hFFFFFFFF, 1, {1'b1, 32'hFFFFF0B7}, 33'd0, 33'd0};
        tbl[2]  = '{2'd0, 5'd3,  32'h12345678, 2, {1'b0, 32'h456781B7}, {1'b1, 32'h12343197}, 33'd0};
        tbl[3]  = '{2'd1, 5'd0,  32'h00200001, 3, {1'b0, 32'hFFFFF07B}, {1'b0, 32'hFFFFF07B}, {1'b1, 32'h0000307B}};
        tbl[4]  = '{2'd1, 5'd0,  32'h00000000, 0, 33'd0, 33'd0, 33'd0};
        tbl[5]  = '{2'd2, 5'd0,  32'hDEADBEEF, 1, {1'b1, 32'hDEADBEEF}, 33'd0, 33'd0};
        tbl[6]  = '{2'd3, 5'd0,  32'hDEADBEEF, 0, 33'd0, 33'd0, 33'd0};
        tbl[7]  = '{2'd0, 5'd0,  32'hFFF80000, 1, {1'b1, 32'h80000037}, 33'd0, 33'd0};
        tbl[8]  = '{2'd0, 5'd0,  32'h00080000, 2, {1'b0, 32'h80000037}, {1'b1, 32'h00080017}, 33'd0};
        tbl[9]  = '{2'd1, 5'd0,  32'h000FFFFF, 1, {1'b1, 32'hFFFFF07B}, 33'd0, 33'd0};
        tbl[10] = '{2'd1, 5'd0,  32'h00100000, 2, {1'b0, 32'hFFFFF07B}, {1'b1, 32'h0000107B}, 33'd0};
        tbl[11] = '{2'd0, 5'd31, 32'hFFF7FFFF, 2, {1'b0, 32'h7FFFFFB7}, {1'b1, 32'hFFF7FF97}, 33'd0};

        // Reset state
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_cmd_err",   64'(cmd_err),   64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        rst = 1'b0;
        step();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // Directed vectors at full rate
        out_ready = 1'b1;
        for (int v = 0; v < 12; v++) begin
            run(tbl[v].op, tbl[v].rd, tbl[v].data, $sformatf("vec%0d", v), 1'b1);
            check($sformatf("vec%0d_tbl_n", v), 64'(got_q.size()), 64'(tbl[v].nw));
            if (got_q.size() > 0) check($sformatf("vec%0d_tbl_w0", v), 64'(got_q[0]), 64'(tbl[v].w0));
            if (got_q.size() > 1) check($sformatf("vec%0d_tbl_w1", v), 64'(got_q[1]), 64'(tbl[v].w1));
            if (got_q.size() > 2) check($sformatf("vec%0d_tbl_w2", v), 64'(got_q[2]), 64'(tbl[v].w2));
        end

        // Backpressure on a two-word LOADI
        out_ready = 1'b0;
        got_q.delete();
        got_t.delete();
        send(2'd0, 5'd3, 32'h12345678);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_instr", 64'(out_instr), 64'h456781B7);
            check("bp_last",  64'(out_last),  64'd0);
            step();
        end
        out_ready = 1'b1;
        drain();
        check("bp_nwords", 64'(got_q.size()), 64'd2);
        if (got_q.size() > 0) check("bp_word0", 64'(got_q[0]), {31'd0, 1'b0, 32'h456781B7});
        if (got_q.size() > 1) check("bp_word1", 64'(got_q[1]), {31'd0, 1'b1, 32'h12343197});

        // Asynchronous reset during the second QWAIT word
        out_ready = 1'b1;
        send(2'd1, 5'd0, 32'h00200001);
        step();
        check("arst_pre_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_busy",  64'(busy),      64'd0);
        check("arst_instr", 64'(out_instr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        vs = valid_seen;
        for (int i = 0; i < 5; i++) step();
        check("arst_no_words", 64'(valid_seen - vs), 64'd0);
        check("arst_ready",    64'(cmd_ready), 64'd1);

        // Longest wait: 4097 words
        out_ready = 1'b1;
        run(2'd1, 5'd0, 32'hFFFFFFFF, "qwmax", 1'b1);
        check("qwmax_n", 64'(got_q.size()), 64'd4097);
        if (got_q.size() > 0)
            check("qwmax_tail", 64'(got_q[got_q.size()-1]), {31'd0, 1'b1, 32'h00FFF07B});

        // Randomized commands with random backpressure
        rand_ready = 1'b1;
        for (int k = 0; k < 80; k++) begin
            rd32 = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: rop = 2'd0;
                4, 5, 6:    rop = 2'd1;
                7, 8:       rop = 2'd2;
                default:    rop = 2'd3;
            endcase
            rdat = $urandom;
            if (rop == 2'd0) begin
                case ($urandom_range(0, 2))
                    0: rdat = $urandom;
                    1: rdat = {{12{rd32[19]}}, rd32[19:0]};
                    default: rdat = {{12{rd32[19]}}, rd32[19:0]} ^ 32'h00100000;
                endcase
            end else if (rop == 2'd1) begin
                case ($urandom_range(0, 2))
                    0: rdat = $urandom_range(1, 32'h00300000);
                    1: rdat = $urandom_range(0, 3) * 32'h000FFFFF + $urandom_range(0, 1);
                    default: rdat = 32'd0;
                endcase
            end
            run(rop, rd32[4:0], rdat, $sformatf("rnd%0d", k), 1'b0);
        end
        rand_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
